// File: rtl/neopix_frame_sequencer.sv
// Frame sequencer for the NeoPixel output path. It walks the pixel memory,
// hands each GRB word to the serializer, waits for the line to drain, then
// holds the latch gap before the next frame may start.
module neopix_frame_sequencer #(
    parameter int unsigned NUM_PIXELS   = 60,
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned RESET_CYCLES = 2500,
    parameter int unsigned FRAME_CYCLES = 833333
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [23:0]       rd_data,
    output logic [23:0]       px_data,
    output logic              px_valid,
    input  logic              px_ready,
    input  logic              ser_idle,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int unsigned FT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned LC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [FT_W-1:0]   FT_LAST  = FT_W'(FRAME_CYCLES - 1);
    localparam logic [LC_W-1:0]   LC_LAST  = LC_W'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND  = 3'd2,
        S_DRAIN = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [FT_W-1:0]   frame_cnt;
    logic [LC_W-1:0]   latch_cnt;
    logic [LC_W-1:0]   latch_cnt_d;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              pending;
    logic              pending_d;
    logic              px_valid_d;
    logic              busy_d;
    logic              frame_done_d;
    logic              overrun_d;
    logic              first_q;
    logic [23:0]       px_hold;

    logic tick;
    logic req;
    logic start;
    logic last_px;

    assign tick    = (frame_cnt == FT_LAST);
    assign req     = tick | frame_req;
    assign start   = (state == S_IDLE) && enable && (pending || req);
    assign last_px = (idx == LAST_IDX);

    // Memory data arrives on the first SEND cycle; forward it then and hold it afterwards.
    assign px_data = first_q ? rd_data : px_hold;

    // Free-running frame-rate timer, independent of the sequencer state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (tick) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + FT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_SEND;
            S_SEND:  if (px_ready) state_d = last_px ? S_DRAIN : S_FETCH;
            S_DRAIN: if (ser_idle) state_d = S_LATCH;
            S_LATCH: if (latch_cnt == LC_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for counters, flags and the registered outputs.
    always_comb begin
        pending_d    = pending;
        idx_d        = idx;
        latch_cnt_d  = '0;
        if (start) begin
            pending_d = 1'b0;
        end else if (req) begin
            pending_d = 1'b1;
        end
        if (start) begin
            idx_d = '0;
        end else if ((state == S_SEND) && px_ready && !last_px) begin
            idx_d = idx + ADDR_W'(1);
        end
        if ((state == S_LATCH) && (state_d == S_LATCH)) begin
            latch_cnt_d = latch_cnt + LC_W'(1);
        end
        rd_addr_d    = (state_d == S_FETCH) ? idx_d : rd_addr;
        px_valid_d   = (state_d == S_SEND);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_LATCH) && (latch_cnt_d == LC_LAST);
        overrun_d    = req && (state != S_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending    <= 1'b0;
            idx        <= '0;
            latch_cnt  <= '0;
            rd_addr    <= '0;
            px_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            first_q    <= 1'b0;
            px_hold    <= '0;
        end else begin
            pending    <= pending_d;
            idx        <= idx_d;
            latch_cnt  <= latch_cnt_d;
            rd_addr    <= rd_addr_d;
            px_valid   <= px_valid_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            overrun    <= overrun_d;
            first_q    <= (state == S_FETCH);
            if (first_q) begin
                px_hold <= rd_data;
            end
        end
    end

endmodule
